// File: rtl/csa_tree_pkg.sv
// Shared helpers for the pipelined carry-save tree: width, level-count and
// stage-count arithmetic evaluated at elaboration time.
package csa_tree_pkg;

    localparam int DEF_NUM_IN    = 9;
    localparam int DEF_DW        = 8;
    localparam int DEF_REG_EVERY = 2;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

    // Operand count after one 3:2 level: each triple becomes two, leftovers pass.
    function automatic int csa_next(input int n);
        return (n > 2) ? (2 * (n / 3) + (n % 3)) : n;
    endfunction

    function automatic int csa_count(input int n, input int lvl);
        int c;
        c = n;
        for (int i = 0; i < lvl; i++) begin
            c = csa_next(c);
        end
        return c;
    endfunction

    function automatic int csa_levels(input int n);
        int c;
        int l;
        c = n;
        l = 0;
        while (c > 2) begin
            c = csa_next(c);
            l = l + 1;
        end
        return l;
    endfunction

    function automatic int csa_stages(input int levels, input int reg_every);
        if (levels == 0) begin
            return 1;
        end
        return (levels + reg_every - 1) / reg_every;
    endfunction

    function automatic int csa_ow(input int num_in, input int dw);
        return dw + clog2(num_in);
    endfunction

    function automatic bit csa_reg_after(input int lvl, input int levels, input int reg_every);
        return (((lvl + 1) % reg_every) == 0) || (lvl == levels - 1);
    endfunction

    localparam int DEF_OW = csa_ow(DEF_NUM_IN, DEF_DW);

endpackage

// File: rtl/compressor_3_2.sv
// Single-bit 3:2 compressor (full adder) used as the tree's leaf cell.
module compressor_3_2 (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ c;
    assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/csa_level_3_2.sv
// One combinational carry-save level: N operands of OW bits in, csa_next(N) out.
// Triples produce (sum, carry<<1); leftover operands are appended unchanged.
module csa_level_3_2
    import csa_tree_pkg::*;
#(
    parameter  int N  = 3,
    parameter  int OW = 8,
    localparam int NO = csa_next(N)
) (
    input  logic [N*OW-1:0]  in_ops,
    output logic [NO*OW-1:0] out_ops
);

    localparam int NT = N / 3;
    localparam int NR = N % 3;

    generate
        for (genvar gi = 0; gi < NT; gi++) begin : g_triple
            logic [OW-1:0] a_w;
            logic [OW-1:0] b_w;
            logic [OW-1:0] c_w;
            logic [OW-1:0] s_w;
            logic [OW-2:0] co_w;

            assign a_w = in_ops[(3*gi)*OW +: OW];
            assign b_w = in_ops[(3*gi+1)*OW +: OW];
            assign c_w = in_ops[(3*gi+2)*OW +: OW];

            for (genvar gb = 0; gb < OW - 1; gb++) begin : g_bit
                compressor_3_2 u_cmp (
                    .a  (a_w[gb]),
                    .b  (b_w[gb]),
                    .c  (c_w[gb]),
                    .s  (s_w[gb]),
                    .co (co_w[gb])
                );
            end

            // The MSB carry would be shifted out of OW bits, so only its sum is built.
            assign s_w[OW-1] = a_w[OW-1] ^ b_w[OW-1] ^ c_w[OW-1];

            assign out_ops[(2*gi)*OW +: OW]   = s_w;
            assign out_ops[(2*gi+1)*OW +: OW] = {co_w, 1'b0};
        end

        for (genvar gi = 0; gi < NR; gi++) begin : g_pass
            assign out_ops[(2*NT+gi)*OW +: OW] = in_ops[(3*NT+gi)*OW +: OW];
        end
    endgenerate

endmodule

// File: rtl/csa_tree_pipe.sv
// Pipelined carry-save reduction tree with valid/ready flow control and a global stall.
// Optional CSA_TREE_FINAL_CPA_EN adds a carry-propagate output stage (out_carry = 0).
module csa_tree_pipe
    import csa_tree_pkg::*;
#(
    parameter  int NUM_IN    = 9,
    parameter  int DW        = 8,
    parameter  int REG_EVERY = 2,
    localparam int OW        = csa_ow(NUM_IN, DW)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NUM_IN*DW-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OW-1:0]        out_sum,
    output logic [OW-1:0]        out_carry
);

    localparam int L = csa_levels(NUM_IN);

    logic                 en;
    logic                 transfer;
    logic [NUM_IN*OW-1:0] ext_ops;
    logic [OW-1:0]        tree_sum;
    logic [OW-1:0]        tree_carry;
    logic                 tree_valid;

    assign en       = !out_valid || out_ready;
    assign in_ready = en && !reset;
    assign transfer = in_valid && in_ready;

    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_ext
            assign ext_ops[gi*OW +: OW] = {{(OW-DW){1'b0}}, in_data[gi*DW +: DW]};
        end

        if (L == 0) begin : g_bypass
            logic [2*OW-1:0] data_d;
            logic [2*OW-1:0] data_q;
            logic            valid_d;
            logic            valid_q;

            always_comb begin
                data_d  = data_q;
                valid_d = valid_q;
                if (en) begin
                    data_d  = ext_ops;
                    valid_d = transfer;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    data_q  <= data_d;
                    valid_q <= valid_d;
                end
            end

            assign tree_sum   = data_q[OW-1:0];
            assign tree_carry = data_q[2*OW-1:OW];
            assign tree_valid = valid_q;
        end else begin : g_tree
            for (genvar gi = 0; gi < L; gi++) begin : g_lvl
                localparam int NI  = csa_count(NUM_IN, gi);
                localparam int NO  = csa_count(NUM_IN, gi + 1);
                localparam bit REG = csa_reg_after(gi, L, REG_EVERY);

                logic [NI*OW-1:0] lin;
                logic             lin_valid;
                logic [NO*OW-1:0] comb_out;
                logic [NO*OW-1:0] lout;
                logic             lout_valid;

                if (gi == 0) begin : g_first
                    assign lin       = ext_ops;
                    assign lin_valid = transfer;
                end else begin : g_next
                    assign lin       = g_lvl[gi-1].lout;
                    assign lin_valid = g_lvl[gi-1].lout_valid;
                end

                csa_level_3_2 #(
                    .N  (NI),
                    .OW (OW)
                ) u_level (
                    .in_ops  (lin),
                    .out_ops (comb_out)
                );

                if (REG) begin : g_reg
                    logic [NO*OW-1:0] data_d;
                    logic [NO*OW-1:0] data_q;
                    logic             valid_d;
                    logic             valid_q;

                    always_comb begin
                        data_d  = data_q;
                        valid_d = valid_q;
                        if (en) begin
                            data_d  = comb_out;
                            valid_d = lin_valid;
                        end
                    end

                    always_ff @(posedge clk) begin
                        if (reset) begin
                            data_q  <= '0;
                            valid_q <= 1'b0;
                        end else begin
                            data_q  <= data_d;
                            valid_q <= valid_d;
                        end
                    end

                    assign lout       = data_q;
                    assign lout_valid = valid_q;
                end else begin : g_comb
                    assign lout       = comb_out;
                    assign lout_valid = lin_valid;
                end
            end

            assign tree_sum   = g_lvl[L-1].lout[OW-1:0];
            assign tree_carry = g_lvl[L-1].lout[2*OW-1:OW];
            assign tree_valid = g_lvl[L-1].lout_valid;
        end
    endgenerate

`ifdef CSA_TREE_FINAL_CPA_EN
    logic [OW-1:0] cpa_sum_d;
    logic [OW-1:0] cpa_sum_q;
    logic          cpa_valid_d;
    logic          cpa_valid_q;

    always_comb begin
        cpa_sum_d   = cpa_sum_q;
        cpa_valid_d = cpa_valid_q;
        if (en) begin
            cpa_sum_d   = tree_sum + tree_carry;
            cpa_valid_d = tree_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cpa_sum_q   <= '0;
            cpa_valid_q <= 1'b0;
        end else begin
            cpa_sum_q   <= cpa_sum_d;
            cpa_valid_q <= cpa_valid_d;
        end
    end

    assign out_sum   = cpa_sum_q;
    assign out_carry = '0;
    assign out_valid = cpa_valid_q;
`else
    assign out_sum   = tree_sum;
    assign out_carry = tree_carry;
    assign out_valid = tree_valid;
`endif

endmodule

// File: tb/tb_csa_tree_pipe.sv
// Directed bench for csa_tree_pipe: default 9x8 instance plus a 2x16 instance.
// Expected latencies follow CSA_TREE_FINAL_CPA_EN when it is defined.
module tb_csa_tree_pipe;

`ifdef CSA_TREE_FINAL_CPA_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int LAT1 = 2 + EXTRA;
    localparam int LAT2 = 1 + EXTRA;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [71:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [11:0] out_sum;
    logic [11:0] out_carry;
    logic [11:0] obs_sum;

    logic        in_valid2 = 1'b0;
    logic        in_ready2;
    logic [31:0] in_data2 = '0;
    logic        out_valid2;
    logic        out_ready2 = 1'b1;
    logic [16:0] out_sum2;
    logic [16:0] out_carry2;
    logic [16:0] obs_sum2;

    int          checks = 0;
    int          errors = 0;
    int          got = 0;
    int          acc = 0;
    logic [11:0] exp_q[$];
    logic        hold_pend = 1'b0;
    logic [11:0] hold_sum;
    logic [11:0] hold_carry;

    assign obs_sum  = out_sum + out_carry;
    assign obs_sum2 = out_sum2 + out_carry2;

    always #5 clk = ~clk;

    csa_tree_pipe #(.NUM_IN(9), .DW(8), .REG_EVERY(2)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry)
    );

    csa_tree_pipe #(.NUM_IN(2), .DW(16), .REG_EVERY(2)) u_dut2 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .in_data   (in_data2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .out_sum   (out_sum2),
        .out_carry (out_carry2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] ref_sum(input logic [71:0] d);
        logic [11:0] s;
        s = '0;
        for (int k = 0; k < 9; k++) begin
            s = s + {4'b0, d[k*8 +: 8]};
        end
        return s;
    endfunction

    function automatic logic [71:0] rand_ops();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[71:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One beat on the default instance; measures latency and checks the reduced sum.
    task automatic single1(input string tag, input logic [71:0] d, input logic [11:0] exp);
        int n;
        in_data  = d;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_latency"}, n, LAT1);
        chk({tag, "_sum"}, obs_sum, exp);
`ifdef CSA_TREE_FINAL_CPA_EN
        chk({tag, "_carry_zero"}, out_carry, 12'h000);
        chk({tag, "_out_sum"}, out_sum, exp);
`endif
        $display("beat %s lat=%0d sum=%03h", tag, n, obs_sum);
        step();
    endtask

    // One streaming cycle: drive, check handshake/hold rules, score outputs, clock.
    task automatic run_cycle(input logic v, input logic [71:0] d, input logic ordy);
        logic [11:0] e;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        #1;
        if (hold_pend) begin
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_sum", out_sum, hold_sum);
            chk("hold_carry", out_carry, hold_carry);
            hold_pend = 1'b0;
        end
        chk("in_ready_rule", in_ready, out_valid ? ordy : 1'b1);
        if (v && in_ready) begin
            exp_q.push_back(ref_sum(d));
            acc++;
        end
        if (out_valid && ordy) begin
            chk("result_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("stream_sum", obs_sum, e);
                $display("result %0d sum=%03h expected=%03h", got, obs_sum, e);
            end
            got++;
        end
        if (out_valid && !ordy) begin
            hold_pend  = 1'b1;
            hold_sum   = out_sum;
            hold_carry = out_carry;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [71:0] d;
        logic [31:0] v2_data [2];
        logic [16:0] v2_exp [2];
        int          stall_left;
        logic        ordy;
        int          n;

        // Reset state.
        step();
        step();
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_sum", out_sum, 12'h000);
        chk("reset_out_carry", out_carry, 12'h000);
        chk("reset_in_ready", in_ready, 1'b0);
        chk("reset_out_valid2", out_valid2, 1'b0);
        reset = 1'b0;
        #1;
        chk("post_reset_in_ready", in_ready, 1'b1);
        $display("reset released in_ready=%0b", in_ready);
        step();

        // Single beats: all 0xFF, 1..9, zeros, lone MSB.
        single1("all_ff", {9{8'hFF}}, 12'h8F7);
        for (int k = 0; k < 9; k++) d[k*8 +: 8] = 8'(k + 1);
        single1("one_to_nine", d, 12'h02D);
        single1("zeros", 72'h0, 12'h000);
        single1("lone_msb", 72'h80, 12'h080);
        d = '0;
        d[71:64] = 8'hFF;
        d[7:0]   = 8'h01;
        single1("first_last", d, 12'h100);

        // Back-to-back stream.
        got = 0;
        acc = 0;
        for (int i = 0; i < 100; i++) run_cycle(1'b1, rand_ops(), 1'b1);
        for (int i = 0; i < LAT1 + 2; i++) run_cycle(1'b0, 72'h0, 1'b1);
        chk("stream_count", got, 100);
        chk("stream_queue_empty", exp_q.size(), 0);

        // Backpressure: 5 stalled cycles after first valid, input continuous.
        got = 0;
        acc = 0;
        stall_left = 5;
        for (int i = 0; i < 14; i++) begin
            ordy = 1'b1;
            if (out_valid && stall_left > 0) begin
                ordy = 1'b0;
                stall_left--;
            end
            run_cycle(1'b1, rand_ops(), ordy);
        end
        for (int i = 0; i < LAT1 + 2; i++) run_cycle(1'b0, 72'h0, 1'b1);
        chk("bp_stall_done", stall_left, 0);
        chk("bp_count", got, acc);
        chk("bp_queue_empty", exp_q.size(), 0);

        // Reset with beats in flight: reset wins over a simultaneous transfer.
        run_cycle(1'b1, {9{8'h11}}, 1'b1);
        run_cycle(1'b1, {9{8'h22}}, 1'b1);
        in_valid = 1'b1;
        reset    = 1'b1;
        step();
        chk("midreset_out_valid", out_valid, 1'b0);
        chk("midreset_out_sum", out_sum, 12'h000);
        chk("midreset_out_carry", out_carry, 12'h000);
        chk("midreset_in_ready", in_ready, 1'b0);
        reset    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) n++;
            step();
        end
        chk("no_stale_result", n, 0);
        $display("mid-flight reset stale_results=%0d", n);

        // Two-operand instance.
        v2_data[0] = {16'h0001, 16'hFFFF};
        v2_exp[0]  = 17'h10000;
        v2_data[1] = {16'h4321, 16'h1234};
        v2_exp[1]  = 17'h05555;
        for (int t = 0; t < 2; t++) begin
            in_data2  = v2_data[t];
            in_valid2 = 1'b1;
            step();
            in_valid2 = 1'b0;
            n = 1;
            while (!out_valid2 && n < 20) begin
                step();
                n++;
            end
            chk("n2_latency", n, LAT2);
            chk("n2_sum", obs_sum2, v2_exp[t]);
`ifdef CSA_TREE_FINAL_CPA_EN
            chk("n2_carry_zero", out_carry2, 17'h0);
`endif
            $display("n2 beat %0d lat=%0d sum=%05h", t, n, obs_sum2);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
